store_buffer: RTL and testbench

//  In-order write buffer between the CPU memory stage and the data memory system (cache hierarchy + main memory).
//  - Absorbs stores so that the memory port is free for loads.
//  - Drains stores oldest-first on cycles when no load uses the port.
//  - Forwards buffered store bytes into load read data, so loads always see program-order memory state.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/sb_fwd_merge.sv | 38 +++
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: entry layout, default
// depth and the byte-lane mask expansion used by the forwarding merge.
package store_buffer_pkg;

  // Default number of buffered stores and the matching pointer width
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  // One buffered store: word address, lane-aligned data and lane enables
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  // Expand 4 byte enables into a 32-bit mask, one byte of ones per lane
  function automatic logic [31:0] sbByteMask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Combinational store-to-load forwarding. Walks the entry ring from the
// oldest slot to the youngest so that younger matching stores overwrite
// older ones lane by lane; lanes no store covers keep the memory data.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t        entries_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PTR_W-1:0] tailPtr_i,
  input  logic [29:0]      ldWaddr_i,
  input  logic [31:0]      memData_i,
  output logic [31:0]      mergedData_o
);

  logic [PTR_W-1:0] scanIdx;
  logic [31:0]      laneMask;

  // Starting at the tail visits slots oldest-first (empty slots are invalid
  // and contribute nothing), so the last writer of a lane is the youngest
  always_comb begin
    mergedData_o = memData_i;
    scanIdx      = '0;
    laneMask     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = tailPtr_i + PTR_W'(k);
      if (valid_i[scanIdx] && (entries_i[scanIdx].waddr == ldWaddr_i)) begin
        laneMask = sbByteMask(entries_i[scanIdx].be);
      end else begin
        laneMask = '0;
      end
      mergedData_o = (mergedData_o & ~laneMask) | (entries_i[scanIdx].data & laneMask);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order write buffer between the CPU memory stage and the memory system.
// Stores are absorbed into a circular FIFO and drained oldest-first on any
// cycle without a load; loads own the memory port and see buffered store
// bytes through the forwarding merge.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = SB_DEPTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid_i,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  input  logic [31:0]           st_data_i,
  input  logic [3:0]            st_byte_en_i,
  output logic                  st_ready_o,
  input  logic                  ld_valid_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [31:0]           mem_rd_data_i,
  output logic [31:0]           ld_rd_data_o,
  input  logic                  fence_i,
  output logic                  fence_busy_o,
  output logic                  empty_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic [3:0]            mem_byte_en_o
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  sb_entry_t        entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic      pushEn;
  logic      popEn;
  sb_entry_t headEntry;
  sb_entry_t newEntry;
  logic [31:0] fwdData;
  logic [1:0]  unusedStByteOffset;

  // Stores are word-granular; the byte offset is carried by the enables
  assign unusedStByteOffset = st_addr_i[1:0];

  // Ready depends on the registered count only, so a pop in the same cycle
  // never lets a store into a full buffer
  assign st_ready_o   = (count_q < FULL_COUNT);
  assign empty_o      = (count_q == '0);
  assign fence_busy_o = fence_i & ~empty_o;

  assign pushEn = st_valid_i & st_ready_o;
  assign popEn  = ~ld_valid_i & ~empty_o;

  assign headEntry      = entry_q[headPtr_q];
  assign newEntry.waddr = st_addr_i[ADDR_WIDTH-1:2];
  assign newEntry.data  = st_data_i;
  assign newEntry.be    = st_byte_en_i;

  // The memory port carries the load on load cycles, otherwise the head store
  assign mem_wr_en_o   = popEn;
  assign mem_addr_o    = ld_valid_i ? ld_addr_i : {headEntry.waddr, 2'b00};
  assign mem_wr_data_o = headEntry.data;
  assign mem_byte_en_o = ld_valid_i ? 4'b1111 : headEntry.be;

  // Forwarding only matters during a load; otherwise pass memory data through
  assign ld_rd_data_o = ld_valid_i ? fwdData : mem_rd_data_i;

  sb_fwd_merge #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_merge (
    .entries_i    (entry_q),
    .valid_i      (valid_q),
    .tailPtr_i    (tailPtr_q),
    .ldWaddr_i    (ld_addr_i[ADDR_WIDTH-1:2]),
    .memData_i    (mem_rd_data_i),
    .mergedData_o (fwdData)
  );

  // Next-state for pointers, count and valid bits; push and pop never target
  // the same slot because a push needs a non-full buffer and a pop a non-empty one
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    valid_d   = valid_q;
    if (popEn) begin
      headPtr_d          = headPtr_q + PTR_ONE;
      valid_d[headPtr_q] = 1'b0;
    end
    if (pushEn) begin
      tailPtr_d          = tailPtr_q + PTR_ONE;
      valid_d[tailPtr_q] = 1'b1;
    end
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every buffered store, even mid-drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
      valid_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
    end
  end

  // Entry payload is qualified by the valid bits, so it needs no reset
  always_ff @(posedge clk) begin
    if (pushEn) begin
      entry_q[tailPtr_q] <= newEntry;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer. A queue models the buffered stores
// in program order: it predicts each memory write, the ready flag and the
// forwarded load data; expected load results are queued when the load is
// driven and popped when the output is sampled.
module tb_store_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        stValid;
  logic [31:0] stAddr;
  logic [31:0] stData;
  logic [3:0]  stByteEn;
  logic        stReady;
  logic        ldValid;
  logic [31:0] ldAddr;
  logic [31:0] memRdData;
  logic [31:0] ldRdData;
  logic        fence;
  logic        fenceBusy;
  logic        empty;
  logic        memWrEn;
  logic [31:0] memAddr;
  logic [31:0] memWrData;
  logic [3:0]  memByteEn;

  int checks;
  int errors;

  wr_t         expWrQ[$];
  logic [31:0] expLdQ[$];

  store_buffer #(
    .DEPTH      (4),
    .ADDR_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid_i    (stValid),
    .st_addr_i     (stAddr),
    .st_data_i     (stData),
    .st_byte_en_i  (stByteEn),
    .st_ready_o    (stReady),
    .ld_valid_i    (ldValid),
    .ld_addr_i     (ldAddr),
    .mem_rd_data_i (memRdData),
    .ld_rd_data_o  (ldRdData),
    .fence_i       (fence),
    .fence_busy_o  (fenceBusy),
    .empty_o       (empty),
    .mem_wr_en_o   (memWrEn),
    .mem_addr_o    (memAddr),
    .mem_wr_data_o (memWrData),
    .mem_byte_en_o (memByteEn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input logic stV, input logic [31:0] stA,
                               input logic [31:0] stD, input logic [3:0] stBe,
                               input logic ldV, input logic [31:0] ldA,
                               input logic [31:0] memD, input logic fen);
    @(posedge clk);
    #1;
    stValid   = stV;
    stAddr    = stA;
    stData    = stD;
    stByteEn  = stBe;
    ldValid   = ldV;
    ldAddr    = ldA;
    memRdData = memD;
    fence     = fen;
  endtask

  // Advance the reference queue by what the coming edge commits
  task automatic modelCommit;
    logic accept;
    wr_t  dropped;
    accept = stValid && (expWrQ.size() < 4);
    if (!ldValid && expWrQ.size() > 0) begin
      dropped = expWrQ.pop_front();
    end
    if (accept) begin
      expWrQ.push_back('{stAddr & ~32'h3, stData, stByteEn});
    end
  endtask

  // Program-order memory view seen by a load: oldest to youngest store
  function automatic logic [31:0] refMerge(input logic [31:0] addr, input logic [31:0] memD);
    logic [31:0] r;
    r = memD;
    foreach (expWrQ[i]) begin
      if (expWrQ[i].addr[31:2] == addr[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (expWrQ[i].be[b]) r[8*b +: 8] = expWrQ[i].data[8*b +: 8];
        end
      end
    end
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    stValid = 1'b0; stAddr = '0; stData = '0; stByteEn = '0;
    ldValid = 1'b0; ldAddr = '0; memRdData = '0; fence = 1'b1;
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
    checks++;
    if (stReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", stReady); end
    checks++;
    if (memWrEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren got %b want 0", memWrEn); end
    checks++;
    if (fenceBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_fence got %b want 0", fenceBusy); end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    fence = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4*i), 32'hA0A0_0000 + 32'(i), 4'hF, 1'b1, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (stReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_fill_ready got %b want 1", stReady); end
      modelCommit();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (memWrEn !== 1'b1 || memAddr !== 32'h40)
      begin errors++; $display("[TB] FAIL reset_predrain got en=%b addr=%h want en=1 addr=00000040", memWrEn, memAddr); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("[TB] FAIL middrain_empty got %b want 1", empty); end
    checks++;
    if (stReady !== 1'b1) begin errors++; $display("[TB] FAIL middrain_ready got %b want 1", stReady); end
    checks++;
    if (memWrEn !== 1'b0) begin errors++; $display("[TB] FAIL middrain_wren got %b want 0", memWrEn); end
    checks++;
    if (fenceBusy !== 1'b0) begin errors++; $display("[TB] FAIL middrain_fence got %b want 0", fenceBusy); end
    expWrQ.delete();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    fence = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (memWrEn !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_wren got %b want 0", memWrEn); end
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4*i), 32'h1000_0000 + 32'(i * 32'h1111), 4'hF,
                    1'b1, 32'h80, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      checks++;
      if (stReady !== (i < 4))
        begin errors++; $display("[TB] FAIL fill_ready[%0d] got %b want %b", i, stReady, (i < 4)); end
      checks++;
      if (memWrEn !== 1'b0 || memAddr !== 32'h80 || memByteEn !== 4'hF)
        begin errors++; $display("[TB] FAIL fill_port got en=%b addr=%h be=%h want en=0 addr=00000080 be=f", memWrEn, memAddr, memByteEn); end
      modelCommit();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (memWrEn !== 1'b1 || memAddr !== 32'h100 + 32'(4*i) || memWrData !== expWrQ[0].data || memByteEn !== expWrQ[0].be)
        begin errors++; $display("[TB] FAIL drain[%0d] got en=%b addr=%h data=%h be=%h want en=1 addr=%h data=%h be=%h",
                                 i, memWrEn, memAddr, memWrData, memByteEn, 32'h100 + 32'(4*i), expWrQ[0].data, expWrQ[0].be); end
      modelCommit();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || memWrEn !== 1'b0)
      begin errors++; $display("[TB] FAIL drain_done got empty=%b en=%b want empty=1 en=0", empty, memWrEn); end
  endtask

  task automatic test_partial_forward;
    logic [31:0] expLd;
    applyStimulus(1'b1, 32'h200, 32'hAABB_CCDD, 4'b0011, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    modelCommit();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200, 32'h1122_3344, 1'b0);
    expLdQ.push_back(32'h1122_CCDD);
    @(negedge clk);
    expLd = expLdQ.pop_front();
    checks++;
    if (ldRdData !== expLd) begin errors++; $display("[TB] FAIL partial_fwd got %h want %h", ldRdData, expLd); end
    checks++;
    if (memWrEn !== 1'b0) begin errors++; $display("[TB] FAIL partial_wren got %b want 0", memWrEn); end
    modelCommit();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (memWrEn !== 1'b1 || memAddr !== 32'h200 || memWrData !== 32'hAABB_CCDD || memByteEn !== 4'b0011)
      begin errors++; $display("[TB] FAIL partial_drain got en=%b addr=%h data=%h be=%h want en=1 addr=00000200 data=aabbccdd be=3",
                               memWrEn, memAddr, memWrData, memByteEn); end
    modelCommit();
  endtask

  task automatic test_youngest_wins;
    logic [31:0] expLd;
    applyStimulus(1'b1, 32'h300, 32'h0000_00AA, 4'b0001, 1'b1, 32'h900, 32'h0, 1'b0);
    @(negedge clk);
    modelCommit();
    applyStimulus(1'b1, 32'h300, 32'h0000_00BB, 4'b0001, 1'b1, 32'h900, 32'h0, 1'b0);
    @(negedge clk);
    modelCommit();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300, 32'h0, 1'b0);
    expLdQ.push_back(32'h0000_00BB);
    @(negedge clk);
    expLd = expLdQ.pop_front();
    checks++;
    if (ldRdData !== expLd) begin errors++; $display("[TB] FAIL youngest got %h want %h", ldRdData, expLd); end
    modelCommit();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (memWrEn !== 1'b1 || memWrData !== ((i == 0) ? 32'hAA : 32'hBB))
        begin errors++; $display("[TB] FAIL youngest_drain[%0d] got en=%b data=%h want en=1 data=%h",
                                 i, memWrEn, memWrData, (i == 0) ? 32'hAA : 32'hBB); end
      modelCommit();
    end
  endtask

  task automatic test_push_pop;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4*i), 32'h5500 + 32'(i), 4'hF, 1'b1, 32'h900, 32'h0, 1'b0);
      @(negedge clk);
      modelCommit();
    end
    applyStimulus(1'b1, 32'h508, 32'h5502, 4'hF, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (memWrEn !== 1'b1 || memAddr !== 32'h500 || stReady !== 1'b1)
      begin errors++; $display("[TB] FAIL pushpop got en=%b addr=%h rdy=%b want en=1 addr=00000500 rdy=1", memWrEn, memAddr, stReady); end
    modelCommit();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i < 2, 32'h50C + 32'(4*i), 32'h5503 + 32'(i), 4'hF, 1'b1, 32'h900, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (stReady !== (i < 2))
        begin errors++; $display("[TB] FAIL pushpop_count[%0d] ready got %b want %b", i, stReady, (i < 2)); end
      modelCommit();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h600 + 32'(4*i), 32'h6600 + 32'(i), 4'hF, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (stReady !== (expWrQ.size() < 4))
        begin errors++; $display("[TB] FAIL wrap_ready[%0d] got %b want %b", i, stReady, (expWrQ.size() < 4)); end
      checks++;
      if (expWrQ.size() == 0 || memWrEn !== 1'b1 || memAddr !== expWrQ[0].addr || memWrData !== expWrQ[0].data)
        begin errors++; $display("[TB] FAIL wrap_write[%0d] got en=%b addr=%h data=%h", i, memWrEn, memAddr, memWrData); end
      modelCommit();
    end
    for (int n = 0; n < 8 && expWrQ.size() > 0; n++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (memWrEn !== 1'b1 || memAddr !== expWrQ[0].addr || memWrData !== expWrQ[0].data)
        begin errors++; $display("[TB] FAIL wrap_drain got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                                 memWrEn, memAddr, memWrData, expWrQ[0].addr, expWrQ[0].data); end
      modelCommit();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_fence;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h700 + 32'(4*i), 32'h7700 + 32'(i), 4'hF, 1'b1, 32'h900, 32'h0, 1'b0);
      @(negedge clk);
      modelCommit();
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (fenceBusy !== (c < 3))
        begin errors++; $display("[TB] FAIL fence_busy[%0d] got %b want %b", c, fenceBusy, (c < 3)); end
      if (c < 3) begin
        checks++;
        if (memWrEn !== 1'b1 || memAddr !== 32'h700 + 32'(4*c))
          begin errors++; $display("[TB] FAIL fence_drain[%0d] got en=%b addr=%h want en=1 addr=%h", c, memWrEn, memAddr, 32'h700 + 32'(4*c)); end
      end
      modelCommit();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_random;
    logic        stV, ldV;
    logic [31:0] stA, stD, ldA, memD, expLd;
    logic [3:0]  stBe;
    for (int c = 0; c < 200; c++) begin
      stV  = 1'($urandom_range(0, 1));
      stA  = 32'h800 + 32'(4 * $urandom_range(0, 1));
      stD  = $urandom;
      stBe = 4'($urandom_range(1, 15));
      ldV  = ($urandom_range(0, 2) == 0);
      ldA  = 32'h800 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      memD = $urandom;
      applyStimulus(stV, stA, stD, stBe, ldV, ldA, memD, 1'b0);
      expLdQ.push_back(ldV ? refMerge(ldA, memD) : memD);
      @(negedge clk);
      expLd = expLdQ.pop_front();
      checks++;
      if (ldRdData !== expLd) begin errors++; $display("[TB] FAIL rand_load[%0d] got %h want %h", c, ldRdData, expLd); end
      checks++;
      if (stReady !== (expWrQ.size() < 4))
        begin errors++; $display("[TB] FAIL rand_ready[%0d] got %b want %b", c, stReady, (expWrQ.size() < 4)); end
      checks++;
      if (!ldV && expWrQ.size() > 0) begin
        if (memWrEn !== 1'b1 || memAddr !== expWrQ[0].addr || memWrData !== expWrQ[0].data || memByteEn !== expWrQ[0].be)
          begin errors++; $display("[TB] FAIL rand_write[%0d] got en=%b addr=%h data=%h be=%h want en=1 addr=%h data=%h be=%h",
                                   c, memWrEn, memAddr, memWrData, memByteEn, expWrQ[0].addr, expWrQ[0].data, expWrQ[0].be); end
      end else begin
        if (memWrEn !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle[%0d] got en=%b want 0", c, memWrEn); end
      end
      modelCommit();
    end
    for (int n = 0; n < 8 && expWrQ.size() > 0; n++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      modelCommit();
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rand_empty got %b want 1", empty); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_drain();
    test_partial_forward();
    test_youngest_wins();
    test_push_pop();
    test_fence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
